nibble_serial_addsub_ctrl: RTL and testbench
============================================

// Module: nibble_serial_addsub_ctrl
// PURPOSE
//   Sequencer that runs wide add/subtract through one shared 4-bit add/sub slice, one nibble per clock, LSB nibble first.
//   Latches operands on a start pulse, chains the carry/borrow between nibbles, then presents the wide result with a done pulse.
//   Sits between a register file/controller and the 4-bit arithmetic slice, trading latency for area.
// PARAMETERS
//   NIBBLES   4   operand width in nibbles; W = 4*NIBBLES (min 1, max 16)
// PORTS
//   clk     in   1    single clock, all state updates on rising edge
//   rst     in   1    synchronous, active-high reset
//   start   in   1    request; sampled only in IDLE
//   op      in   1    1 = add (a+b), 0 = subtract (a-b); same encoding as the 4-bit slice select
//   a       in   W    operand A, sampled with start
//   b       in   W    operand B, sampled with start
//   busy    out  1    high while in RUN
//   done    out  1    one-cycle pulse; result/cout valid from this cycle
//   result  out  W    wide sum/difference; held until next accepted start
//   cout    out  1    add: carry out of MSB; sub: borrow (1 iff a<b unsigned)
//   ovf     out  1    signed overflow; present only with SIGNED_OVF_EN
// BEHAVIOUR
//   Reset (rst=1 at edge): state=IDLE, busy=0, done=0, result=0, cout=0, ovf=0, nibble counter=0, internal carry=0.
//   rst dominates all other inputs, including mid-RUN: operation discarded, no done pulse.
//   States: IDLE -> RUN -> DONE -> IDLE.
//     IDLE: start=1 -> latch a, b, op; idx=0; carry_in = (op==0); -> RUN. start=0 -> stay.
//     RUN : per cycle, process nibble idx: add: {c,s}=A[idx]+B[idx]+cin; sub: {c,s}=A[idx]+~B[idx]+cin.
//           Write s into result[4*idx+3:4*idx]; cin<=c; idx<=idx+1. After nibble NIBBLES-1 -> DONE.
//     DONE: done=1 for exactly this cycle; cout = final c (add) or ~final c (sub); -> IDLE.
//   Latency: start high at cycle 0 -> busy high cycles 1..NIBBLES, done high cycle NIBBLES+1; busy=0 in DONE.
//   start is ignored in RUN and DONE (no queueing); next accepted start is earliest cycle NIBBLES+2.
//   a/b/op changes after acceptance have no effect (operands latched).
//   Arithmetic modulo 2^W: {cout,result} equals (W+1)-bit a+b (add) or a-b (sub, cout=borrow).
//   result nibbles not yet written during RUN are undefined to the consumer; only sample at/after done.
//   result and cout hold their value in IDLE until the next operation's writes begin.
//   NIBBLES=1: RUN lasts one cycle; behaviour identical to the 4-bit slice plus two cycles latency.
// CONFIGURATION
//   SIGNED_OVF_EN defined: port ovf exists; in DONE, ovf = carry into MSB xor carry out of MSB
//     (two's-complement overflow for the chosen op); held with result; cleared by rst.
//   SIGNED_OVF_EN undefined: no ovf port, no overflow logic; all other behaviour identical.
// TESTING (NIBBLES=4 unless noted)
//   add 0x1234+0x0FFF, start 1 cycle -> done at cycle 5, result=0x2233, cout=0, busy high cycles 1-4.
//   add 0xFFFF+0x0001 -> result=0x0000, cout=1 (full ripple through all nibbles).
//   sub 0x0005-0x0007 -> result=0xFFFE, cout=1; sub 0x8000-0x0001 -> result=0x7FFF, cout=0, ovf=1 (SIGNED_OVF_EN).
//   start held high continuously + a/b toggled during RUN -> one done per NIBBLES+2 cycles, result from latched operands.
//   rst=1 at cycle 2 of RUN -> next cycle busy=0, done never pulses, result=0, cout=0; new start then completes normally.
//   NIBBLES=1: sub 0x3-0x5 -> result=0xE, cout=1, done at cycle 2.

Source files
------------

// File: rtl/nibble_serial_addsub_ctrl.sv
// Wide add/subtract sequenced through one 4-bit slice, LSB nibble first, one nibble per clock.
// Optional macro SIGNED_OVF_EN adds the o_ovf port (two's-complement overflow of the final result).
module nibble_serial_addsub_ctrl #(
  parameter  int NIBBLES = 4,
  localparam int W       = 4*NIBBLES
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic         i_op,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_busy,
  output logic         o_done,
  output logic [W-1:0] o_result,
  output logic         o_cout
`ifdef SIGNED_OVF_EN
  ,
  output logic         o_ovf
`endif
);

  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t         r_state, w_next;
  logic [W-1:0]   r_a, r_b, r_result;
  logic           r_op, r_cin, r_cout;
  logic [IW-1:0]  r_idx;
  logic [3:0]     w_a_nib, w_b_raw, w_b_nib;
  logic [4:0]     w_sum;
  logic           w_last, w_accept;

  // The shared slice: subtract is A + ~B with the initial carry preset to 1.
  assign w_a_nib = 4'(r_a >> {r_idx, 2'b00});
  assign w_b_raw = 4'(r_b >> {r_idx, 2'b00});
  assign w_b_nib = r_op ? w_b_raw : ~w_b_raw;
  assign w_sum   = {1'b0, w_a_nib} + {1'b0, w_b_nib} + {4'b0, r_cin};
  assign w_last  = (r_idx == IW'(NIBBLES-1));

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    o_busy   = 1'b0;
    o_done   = 1'b0;
    case (r_state)
      S_IDLE: if (i_start) begin
        w_accept = 1'b1;
        w_next   = S_RUN;
      end
      S_RUN: begin
        o_busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

`ifdef SIGNED_OVF_EN
  logic r_ovf;
  assign o_ovf = r_ovf;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= 1'b0;
      r_cin    <= 1'b0;
      r_idx    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
`ifdef SIGNED_OVF_EN
      r_ovf    <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a   <= i_a;
      r_b   <= i_b;
      r_op  <= i_op;
      r_idx <= '0;
      r_cin <= ~i_op;
    end else if (r_state == S_RUN) begin
      for (int n = 0; n < NIBBLES; n++)
        if (r_idx == IW'(n)) r_result[4*n +: 4] <= w_sum[3:0];
      r_cin <= w_sum[4];
      r_idx <= r_idx + 1'b1;
      if (w_last) begin
        r_cout <= r_op ? w_sum[4] : ~w_sum[4];
`ifdef SIGNED_OVF_EN
        // Carry into the MSB is recovered from the top bit's sum: a ^ b ^ s.
        r_ovf  <= w_sum[4] ^ (w_a_nib[3] ^ w_b_nib[3] ^ w_sum[3]);
`endif
      end
    end
  end

  assign o_result = r_result;
  assign o_cout   = r_cout;

endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// Randomized self-checking bench for nibble_serial_addsub_ctrl (NIBBLES=4 plus a NIBBLES=1 instance).
module tb_nibble_serial_addsub_ctrl;
  localparam int N = 4;
  localparam int W = 4*N;

  logic         clk = 1'b0;
  logic         rst, start, op;
  logic [W-1:0] a, b, result;
  logic         busy, done, cout, ovf;
  logic         start1, op1, busy1, done1, cout1, ovf1;
  logic [3:0]   a1, b1, result1;
  int           n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  nibble_serial_addsub_ctrl #(.NIBBLES(N)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op), .i_a(a), .i_b(b),
    .o_busy(busy), .o_done(done), .o_result(result), .o_cout(cout)
`ifdef SIGNED_OVF_EN
    , .o_ovf(ovf)
`endif
  );

  nibble_serial_addsub_ctrl #(.NIBBLES(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .i_op(op1), .i_a(a1), .i_b(b1),
    .o_busy(busy1), .o_done(done1), .o_result(result1), .o_cout(cout1)
`ifdef SIGNED_OVF_EN
    , .o_ovf(ovf1)
`endif
  );

`ifndef SIGNED_OVF_EN
  assign ovf  = 1'b0;
  assign ovf1 = 1'b0;
`endif

  // Reference: plain (W+1)-bit arithmetic; cout on subtract is the unsigned borrow.
  function automatic logic [W:0] ref_calc(input logic [W-1:0] x, y, input logic o);
    if (o) return {1'b0, x} + {1'b0, y};
    return {(x < y), x - y};
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, y, input logic o);
    logic [W-1:0] r;
    r = o ? x + y : x - y;
    if (o) return (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    return (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
  endfunction

  // Issues one start, scrambles inputs afterwards, waits (bounded) for done.
  task automatic do_op(input logic [W-1:0] ta, tb_, input logic to,
                       output logic [W-1:0] r, output logic co, output logic ov,
                       output int dc, output logic [15:0] bm);
    @(negedge clk);
    a = ta; b = tb_; op = to; start = 1'b1;
    dc = -1; bm = '0; r = '0; co = 1'b0; ov = 1'b0;
    for (int c = 1; c < 16; c++) begin
      @(negedge clk);
      start = 1'b0; a = W'($urandom); b = W'($urandom); op = 1'($urandom);
      bm[c] = busy;
      if (done) begin
        dc = c; r = result; co = cout; ov = ovf;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    start1 = 1'b0; op1 = 1'b0; a1 = '0; b1 = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, result, cout, ovf} !== '0) begin
      n_fail++;
      $display("FAIL reset: busy=%b done=%b result=%h cout=%b ovf=%b, want all 0", busy, done, result, cout, ovf);
    end
    n_checks++;
    if ({busy1, done1, result1, cout1, ovf1} !== '0) begin
      n_fail++;
      $display("FAIL reset1: busy=%b done=%b result=%h cout=%b, want all 0", busy1, done1, result1, cout1);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed;
    logic [W-1:0] ta [4] = '{16'h1234, 16'hFFFF, 16'h0005, 16'h8000};
    logic [W-1:0] tb_[4] = '{16'h0FFF, 16'h0001, 16'h0007, 16'h0001};
    logic         to [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [W-1:0] r; logic co, ov; int dc; logic [15:0] bm; logic [W:0] e;
    for (int i = 0; i < 4; i++) begin
      do_op(ta[i], tb_[i], to[i], r, co, ov, dc, bm);
      e = ref_calc(ta[i], tb_[i], to[i]);
      n_checks++;
      if (dc != N+1 || bm != 16'h001E) begin
        n_fail++;
        $display("FAIL latency[%0d]: done_cycle=%0d busy_mask=%h, want %0d / 001e", i, dc, bm, N+1);
      end
      n_checks++;
      if ({co, r} !== e) begin
        n_fail++;
        $display("FAIL directed[%0d]: cout,result=%h, want %h", i, {co, r}, e);
      end
`ifdef SIGNED_OVF_EN
      n_checks++;
      if (ov !== ref_ovf(ta[i], tb_[i], to[i])) begin
        n_fail++;
        $display("FAIL ovf[%0d]: ovf=%b, want %b", i, ov, ref_ovf(ta[i], tb_[i], to[i]));
      end
`endif
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || {cout, result} !== e) begin
        n_fail++;
        $display("FAIL hold[%0d]: done=%b busy=%b cout,result=%h, want 0 0 %h", i, done, busy, {cout, result}, e);
      end
    end
  endtask

  task automatic test_random;
    logic [W-1:0] x, y, r; logic o, co, ov; int dc; logic [15:0] bm;
    for (int i = 0; i < 40; i++) begin
      x = W'($urandom); y = W'($urandom); o = 1'($urandom);
      if (i % 8 == 0) y = x;
      do_op(x, y, o, r, co, ov, dc, bm);
      n_checks++;
      if (dc != N+1 || {co, r} !== ref_calc(x, y, o)
`ifdef SIGNED_OVF_EN
          || ov !== ref_ovf(x, y, o)
`endif
         ) begin
        n_fail++;
        $display("FAIL random[%0d] %h %s %h: dc=%0d cout,result=%h ovf=%b, want dc=%0d %h", i, x, o ? "+" : "-", y,
                 dc, {co, r}, ov, N+1, ref_calc(x, y, o));
      end
    end
  endtask

  // start held high with inputs changing every cycle: accepts fall every N+2 cycles.
  task automatic test_back_to_back;
    logic [W-1:0] xa [32]; logic [W-1:0] xb [32]; logic xo [32];
    int ndone = 0;
    @(negedge clk);
    for (int c = 0; c < 30; c++) begin
      if (c >= 1) begin
        n_checks++;
        if (c % (N+2) == N+1) begin
          ndone++;
          if (done !== 1'b1 || {cout, result} !== ref_calc(xa[c-N-1], xb[c-N-1], xo[c-N-1])) begin
            n_fail++;
            $display("FAIL b2b cycle %0d: done=%b cout,result=%h, want 1 %h", c, done, {cout, result},
                     ref_calc(xa[c-N-1], xb[c-N-1], xo[c-N-1]));
          end
        end else if (done !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b cycle %0d: done=%b, want 0", c, done);
        end
      end
      xa[c] = W'($urandom); xb[c] = W'($urandom); xo[c] = 1'($urandom);
      a = xa[c]; b = xb[c]; op = xo[c]; start = 1'b1;
      @(negedge clk);
      c = c;
    end
    start = 1'b0;
    n_checks++;
    if (ndone != 5) begin
      n_fail++;
      $display("FAIL b2b count: %0d done pulses checked, want 5", ndone);
    end
  endtask

  task automatic test_reset_mid_run;
    logic [W-1:0] r; logic co, ov; int dc; logic [15:0] bm; int seen = 0;
    @(negedge clk);
    a = 16'hABCD; b = 16'h1357; op = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    n_checks++;
    if ({busy, done, result, cout} !== '0) begin
      n_fail++;
      $display("FAIL midrst: busy=%b done=%b result=%h cout=%b, want all 0", busy, done, result, cout);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL midrst_done: %0d done pulses after reset, want 0", seen);
    end
    do_op(16'h7FFF, 16'h0001, 1'b1, r, co, ov, dc, bm);
    n_checks++;
    if (dc != N+1 || {co, r} !== 17'h08000) begin
      n_fail++;
      $display("FAIL midrst_after: dc=%0d cout,result=%h, want %0d 08000", dc, {co, r}, N+1);
    end
  endtask

  task automatic test_nibbles1;
    logic [3:0] x, y; logic o; logic [4:0] e; int dc;
    for (int i = 0; i < 9; i++) begin
      if (i == 0) begin x = 4'h3; y = 4'h5; o = 1'b0; end
      else begin x = 4'($urandom); y = 4'($urandom); o = 1'($urandom); end
      e = o ? {1'b0, x} + {1'b0, y} : {(x < y), x - y};
      @(negedge clk);
      a1 = x; b1 = y; op1 = o; start1 = 1'b1; dc = -1;
      for (int c = 1; c < 8; c++) begin
        @(negedge clk);
        start1 = 1'b0; a1 = 4'($urandom); b1 = 4'($urandom);
        if (done1) begin dc = c; break; end
      end
      n_checks++;
      if (dc != 2 || {cout1, result1} !== e) begin
        n_fail++;
        $display("FAIL nib1[%0d]: dc=%0d cout,result=%h, want 2 %h", i, dc, {cout1, result1}, e);
      end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_back_to_back;
    test_reset_mid_run;
    test_nibbles1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
